spi_master_multi_cs: RTL and testbench
======================================

# spi_master_multi_cs

Parametrised SPI master that generalises the single-slave byte master to N chip-select lines, configurable word width, bit order and CS lead/inactive timing. It accepts a burst of 1..MAX_WORDS_PER_CS words over a valid/ready handshake and keeps the selected CS asserted for the whole burst. It returns each received word with a one-cycle strobe and a zero-based word index. It sits between the host-side command logic and the top-level SPI pads.

## Interface
- SPI_MODE, 0: {CPOL,CPHA}; 0=00, 1=01, 2=10, 3=11; fixed per instance
- CLKS_PER_HALF_BIT, 2: i_clk cycles per SCLK half period (H), ≥2
- WORD_BITS, 8: bits per word (W), 4..32
- MSB_FIRST, 1: 1 = MSB shifted first, 0 = LSB first
- NUM_CS, 2: number of CS_n lines, ≥1
- MAX_WORDS_PER_CS, 2: longest burst
- CS_LEAD_CLKS, 1: cycles from CS assert to word start, ≥1
- CS_INACTIVE_CLKS, 1: minimum CS-high cycles between bursts, ≥1
- Derived: CW = $clog2(MAX_WORDS_PER_CS+1); SW = max(1, $clog2(NUM_CS))

Ports:
- i_clk  in  1  sole clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_TX_count  in  CW  burst length, sampled with the first word
- i_TX_CS_sel  in  SW  CS index, sampled with the first word
- i_TX_Word  in  W  transmit word
- i_TX_DV  in  1  transmit valid
- o_TX_Ready  out  1  accept; transfer occurs on i_TX_DV & o_TX_Ready
- o_RX_DV  out  1  one-cycle receive strobe
- o_RX_Word  out  W  received word, valid with o_RX_DV
- o_RX_count  out  CW  zero-based index of the word in the burst, valid with o_RX_DV
- o_SPI_clk  out  1  SCLK
- i_SPI_MISO  in  1  serial in
- o_SPI_MOSI  out  1  serial out
- o_SPI_CS_n  out  NUM_CS  active-low chip selects

## Operation
- Reset values on the first i_clk edge with i_rst_n=0:
  - state = IDLE
  - o_SPI_CS_n = all ones
  - o_SPI_clk = CPOL
  - o_SPI_MOSI = 0
  - o_RX_DV = 0
  - o_RX_Word = 0
  - o_RX_count = 0
  - remaining-word counter = 0
- Reset mid-word aborts the word with no o_RX_DV.
- States:
  - IDLE: accept the first word and latch count and sel. Count 0 is treated as 1. Set remaining = count−1. Go to LEAD.
  - LEAD: CS_n[sel] low; wait CS_LEAD_CLKS cycles, then go to XFER and start the engine.
  - XFER: on each word end, pulse o_RX_DV.
    - If remaining > 0: wait, with CS held low and no timeout, for the next accepted word. The engine starts the cycle after acceptance; decrement remaining.
    - If remaining = 0: go to INACTIVE.
  - INACTIVE: all CS_n high for CS_INACTIVE_CLKS cycles, then go to IDLE.
- o_TX_Ready = (state==IDLE) | (state==XFER & engine idle & remaining>0). It is a function of registers only and never depends on i_TX_DV.
- i_TX_count and i_TX_CS_sel are ignored outside IDLE acceptance.
- If sel ≥ NUM_CS, the burst runs normally with all CS_n high.
- o_RX_count clears to 0 on the INACTIVE→IDLE transition and increments after each o_RX_DV. It wraps naturally at 2^CW, which is unreachable.
- Bit order follows MSB_FIRST for both MOSI and MISO. The received word is assembled in the same order as transmitted.
- CPHA=0: MOSI presents the first bit at engine start. MISO is sampled on odd edges; MOSI shifts on even edges except the last.
- CPHA=1: MOSI shifts on odd edges and MISO is sampled on even edges.
- o_SPI_MOSI holds its last bit between words and returns to 0 in IDLE.

## Timing
- Let S be the engine-start cycle and H = CLKS_PER_HALF_BIT.
- SCLK edge k (k = 1..2W) is visible from cycle S + k·H. SCLK rests at CPOL between words.
- o_RX_DV is high exactly in cycle S + 2W·H + 1. The engine is idle, and o_TX_Ready may assert, in that same cycle.
- First word: accepted at T; CS_n[sel] low from T+1; S = T + 1 + CS_LEAD_CLKS.
- Later words: accepted at A; S = A+1. The minimum gap between words is 1 cycle of SCLK at CPOL.
- Last word: o_RX_DV at D; CS_n high from D+1; o_TX_Ready high from D + 1 + CS_INACTIVE_CLKS.
- i_TX_DV held continuously chains words back-to-back with no bubble beyond the above.

## Structure
- Package spi_pkg:
  - state encoding (IDLE, LEAD, XFER, INACTIVE)
  - CPOL/CPHA decode functions
  - width helper for CW/SW
- Sub-module spi_word_engine (params SPI_MODE, CLKS_PER_HALF_BIT, WORD_BITS, MSB_FIRST):
  - start pulse in
  - idle, done strobe, RX word, SCLK and MOSI out
- The top holds the CS state machine, counters and handshake.

## Test plan
- Mode 0, H=2, W=8, count=1, sel=1, TX 0xA5, MISO loopback → CS_n=2'b01 for the burst; MOSI bits 1,0,1,0,0,1,0,1 on rising edges; o_RX_DV at S+33 with o_RX_Word=0xA5 and o_RX_count=0.
- Mode 3, count=3, words 0x01/0x02/0x03 with DV held → 3 strobes with o_RX_count 0,1,2; CS_n low continuously; 1-cycle gaps between words; CS_n high CS_INACTIVE_CLKS cycles before o_TX_Ready.
- Count=2 with the second DV delayed 50 cycles → CS stays low and SCLK stays at CPOL during the gap; the burst completes normally.
- W=12, MSB_FIRST=0, mode 1, TX 0x5C3, MISO driven with 0x3A5 → o_RX_Word=0x3A5; MOSI LSB first.
- Count=0 and sel=NUM_CS → one word transferred; all CS_n high.
- i_rst_n low at mid-word for 1 cycle → next cycle all outputs at their reset values; no o_RX_DV; a new burst after release works.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the multi-CS SPI master
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LEAD     = 2'd1,
        ST_XFER     = 2'd2,
        ST_INACTIVE = 2'd3
    } spi_state_e;

    // Clock polarity is bit 1 of the SPI mode number.
    function automatic logic spi_cpol(input int mode);
        return (mode & 2) != 0;
    endfunction

    // Clock phase is bit 0 of the SPI mode number.
    function automatic logic spi_cpha(input int mode);
        return (mode & 1) != 0;
    endfunction

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int spi_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_word_engine.sv
// rtl/spi_word_engine.sv - shifts one word in and out with SCLK generation
module spi_word_engine
    import spi_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int WORD_BITS         = 8,
    parameter int MSB_FIRST         = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_clr,
    input  logic [WORD_BITS-1:0] i_tx_word,
    input  logic                 i_miso,
    output logic                 o_idle,
    output logic                 o_done,
    output logic [WORD_BITS-1:0] o_rx_word,
    output logic                 o_sclk,
    output logic                 o_mosi
);

    localparam logic          CPOL      = spi_cpol(SPI_MODE);
    localparam logic          CPHA      = spi_cpha(SPI_MODE);
    localparam int            HW        = spi_width(CLKS_PER_HALF_BIT);
    localparam int            EW        = spi_width(2 * WORD_BITS + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * WORD_BITS);
    localparam logic [EW-1:0] EDGE_PRE  = EW'(2 * WORD_BITS - 1);

    logic                 r_busy;
    logic                 r_done;
    logic [HW-1:0]        r_half_cnt;
    logic [EW-1:0]        r_edge_cnt;
    logic [WORD_BITS-1:0] r_tx_sr;
    logic [WORD_BITS-1:0] r_rx_sr;
    logic                 r_sclk;
    logic                 r_mosi;
    logic                 w_odd_edge;
    logic                 w_sample;
    logic                 w_shift;

    function automatic logic head_bit(input logic [WORD_BITS-1:0] w);
        return (MSB_FIRST != 0) ? w[WORD_BITS-1] : w[0];
    endfunction

    function automatic logic [WORD_BITS-1:0] drop_head(input logic [WORD_BITS-1:0] w);
        return (MSB_FIRST != 0) ? {w[WORD_BITS-2:0], 1'b0} : {1'b0, w[WORD_BITS-1:1]};
    endfunction

    // Classify the edge about to be produced: odd edges are 1,3,5...
    always_comb begin
        w_odd_edge = ~r_edge_cnt[0];
        w_sample   = CPHA ? ~w_odd_edge : w_odd_edge;
        w_shift    = CPHA ? w_odd_edge : (~w_odd_edge && (r_edge_cnt != EDGE_PRE));
    end

    // Half-period timer, edge counter and the two shift registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_half_cnt <= '0;
            r_edge_cnt <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_sclk     <= CPOL;
            r_mosi     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                if (r_edge_cnt == EDGE_LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else if (r_half_cnt == HALF_LAST) begin
                    r_half_cnt <= '0;
                    r_sclk     <= ~r_sclk;
                    r_edge_cnt <= r_edge_cnt + 1'b1;
                    if (w_sample) begin
                        r_rx_sr <= (MSB_FIRST != 0) ? {r_rx_sr[WORD_BITS-2:0], i_miso}
                                                    : {i_miso, r_rx_sr[WORD_BITS-1:1]};
                    end
                    if (w_shift) begin
                        r_mosi  <= head_bit(r_tx_sr);
                        r_tx_sr <= drop_head(r_tx_sr);
                    end
                end else begin
                    r_half_cnt <= r_half_cnt + 1'b1;
                end
            end else if (i_start) begin
                r_busy     <= 1'b1;
                r_half_cnt <= '0;
                r_edge_cnt <= '0;
                r_sclk     <= CPOL;
                if (!CPHA) begin
                    r_mosi  <= head_bit(i_tx_word);
                    r_tx_sr <= drop_head(i_tx_word);
                end else begin
                    r_tx_sr <= i_tx_word;
                end
            end else if (i_clr) begin
                r_mosi <= 1'b0;
            end
        end
    end

    assign o_idle    = ~r_busy;
    assign o_done    = r_done;
    assign o_rx_word = r_rx_sr;
    assign o_sclk    = r_sclk;
    assign o_mosi    = r_mosi;

endmodule

// File: rtl/spi_master_multi_cs.sv
// rtl/spi_master_multi_cs.sv - burst SPI master with N chip selects
module spi_master_multi_cs
    import spi_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int WORD_BITS         = 8,
    parameter int MSB_FIRST         = 1,
    parameter int NUM_CS            = 2,
    parameter int MAX_WORDS_PER_CS  = 2,
    parameter int CS_LEAD_CLKS      = 1,
    parameter int CS_INACTIVE_CLKS  = 1,
    localparam int CW = spi_width(MAX_WORDS_PER_CS + 1),
    localparam int SW = spi_width(NUM_CS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [CW-1:0]        i_TX_count,
    input  logic [SW-1:0]        i_TX_CS_sel,
    input  logic [WORD_BITS-1:0] i_TX_Word,
    input  logic                 i_TX_DV,
    output logic                 o_TX_Ready,
    output logic                 o_RX_DV,
    output logic [WORD_BITS-1:0] o_RX_Word,
    output logic [CW-1:0]        o_RX_count,
    output logic                 o_SPI_clk,
    input  logic                 i_SPI_MISO,
    output logic                 o_SPI_MOSI,
    output logic [NUM_CS-1:0]    o_SPI_CS_n
);

    localparam int TMR_MAX = (CS_LEAD_CLKS > CS_INACTIVE_CLKS) ? CS_LEAD_CLKS : CS_INACTIVE_CLKS;
    localparam int TW      = spi_width(TMR_MAX + 1);

    spi_state_e           r_state;
    spi_state_e           w_next_state;
    logic [TW-1:0]        r_tmr;
    logic [CW-1:0]        r_remaining;
    logic [CW-1:0]        r_rx_count;
    logic [SW-1:0]        r_sel;
    logic [WORD_BITS-1:0] r_first_word;
    logic                 w_tx_ready;
    logic                 w_accept;
    logic                 w_start;
    logic                 w_idle;
    logic                 w_done;
    logic                 w_sclk;
    logic                 w_mosi;
    logic [WORD_BITS-1:0] w_rx_word;
    logic [WORD_BITS-1:0] w_eng_word;
    logic [NUM_CS-1:0]    w_cs_n;

    // Handshake, engine start and next-state decode.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_tx_ready   = (r_state == ST_IDLE) ||
                       ((r_state == ST_XFER) && w_idle && (r_remaining != '0));
        w_accept     = i_TX_DV && w_tx_ready;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next_state = ST_LEAD;
            end
            ST_LEAD: begin
                if (r_tmr == TW'(CS_LEAD_CLKS - 1)) begin
                    w_next_state = ST_XFER;
                    w_start      = 1'b1;
                end
            end
            ST_XFER: begin
                if (w_accept) begin
                    w_start = 1'b1;
                end else if (w_done && (r_remaining == '0)) begin
                    w_next_state = ST_INACTIVE;
                end
            end
            default: begin
                if (r_tmr == TW'(CS_INACTIVE_CLKS - 1)) w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Burst bookkeeping: phase timer, word counters and latched first word/select.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tmr        <= '0;
            r_remaining  <= '0;
            r_rx_count   <= '0;
            r_sel        <= '0;
            r_first_word <= '0;
        end else begin
            if (r_state != w_next_state) begin
                r_tmr <= '0;
            end else if ((r_state == ST_LEAD) || (r_state == ST_INACTIVE)) begin
                r_tmr <= r_tmr + 1'b1;
            end
            if ((r_state == ST_IDLE) && w_accept) begin
                r_first_word <= i_TX_Word;
                r_sel        <= i_TX_CS_sel;
                r_remaining  <= (i_TX_count == '0) ? '0 : i_TX_count - 1'b1;
            end else if ((r_state == ST_XFER) && w_accept) begin
                r_remaining <= r_remaining - 1'b1;
            end
            if (w_done) begin
                r_rx_count <= r_rx_count + 1'b1;
            end else if ((r_state == ST_INACTIVE) && (w_next_state == ST_IDLE)) begin
                r_rx_count <= '0;
            end
        end
    end

    // Drive the selected CS low through LEAD and XFER; out-of-range selects drive none.
    always_comb begin
        w_cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (((r_state == ST_LEAD) || (r_state == ST_XFER)) && (SW'(i) == r_sel)) begin
                w_cs_n[i] = 1'b0;
            end
        end
    end

    assign w_eng_word = (r_state == ST_XFER) ? i_TX_Word : r_first_word;

    spi_word_engine #(
        .SPI_MODE          (SPI_MODE),
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT),
        .WORD_BITS         (WORD_BITS),
        .MSB_FIRST         (MSB_FIRST)
    ) u_engine (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (w_start),
        .i_clr     (r_state == ST_IDLE),
        .i_tx_word (w_eng_word),
        .i_miso    (i_SPI_MISO),
        .o_idle    (w_idle),
        .o_done    (w_done),
        .o_rx_word (w_rx_word),
        .o_sclk    (w_sclk),
        .o_mosi    (w_mosi)
    );

    assign o_TX_Ready = w_tx_ready;
    assign o_RX_DV    = w_done;
    assign o_RX_Word  = w_rx_word;
    assign o_RX_count = r_rx_count;
    assign o_SPI_clk  = w_sclk;
    assign o_SPI_MOSI = (r_state == ST_IDLE) ? 1'b0 : w_mosi;
    assign o_SPI_CS_n = w_cs_n;

endmodule

// File: tb/tb_spi_master_multi_cs.sv
// tb/tb_spi_master_multi_cs.sv - scoreboard bench for spi_master_multi_cs
module tb_spi_master_multi_cs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // u0: mode 0, W=8, MSB first, 2 CS, loopback
    logic       rst0 = 1'b0, dv_in0 = 1'b0, sel_in0 = 1'b0;
    logic [1:0] cnt_in0 = '0;
    logic [7:0] word_in0 = '0;
    logic       ready0, dv0, sclk0, mosi0;
    logic [7:0] rxw0;
    logic [1:0] rxc0, cs0;

    // u3: mode 3, W=8, 3 CS, MAX 3 words, 2 inactive clocks, loopback
    logic       rst3 = 1'b0, dv_in3 = 1'b0;
    logic [1:0] cnt_in3 = '0, sel_in3 = '0;
    logic [7:0] word_in3 = '0;
    logic       ready3, dv3, sclk3, mosi3;
    logic [7:0] rxw3;
    logic [1:0] rxc3;
    logic [2:0] cs3;

    // u1: mode 1, W=12, LSB first, slave model on MISO
    logic        rst1 = 1'b0, dv_in1 = 1'b0, sel_in1 = 1'b0, miso1 = 1'b0;
    logic [1:0]  cnt_in1 = '0;
    logic [11:0] word_in1 = '0;
    logic        ready1, dv1, sclk1, mosi1;
    logic [11:0] rxw1;
    logic [1:0]  rxc1, cs1;

    spi_master_multi_cs #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(2), .WORD_BITS(8), .MSB_FIRST(1),
        .NUM_CS(2), .MAX_WORDS_PER_CS(2), .CS_LEAD_CLKS(1), .CS_INACTIVE_CLKS(1)) u0 (
        .i_clk(clk), .i_rst_n(rst0), .i_TX_count(cnt_in0), .i_TX_CS_sel(sel_in0),
        .i_TX_Word(word_in0), .i_TX_DV(dv_in0), .o_TX_Ready(ready0), .o_RX_DV(dv0),
        .o_RX_Word(rxw0), .o_RX_count(rxc0), .o_SPI_clk(sclk0), .i_SPI_MISO(mosi0),
        .o_SPI_MOSI(mosi0), .o_SPI_CS_n(cs0));

    spi_master_multi_cs #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(2), .WORD_BITS(8), .MSB_FIRST(1),
        .NUM_CS(3), .MAX_WORDS_PER_CS(3), .CS_LEAD_CLKS(1), .CS_INACTIVE_CLKS(2)) u3 (
        .i_clk(clk), .i_rst_n(rst3), .i_TX_count(cnt_in3), .i_TX_CS_sel(sel_in3),
        .i_TX_Word(word_in3), .i_TX_DV(dv_in3), .o_TX_Ready(ready3), .o_RX_DV(dv3),
        .o_RX_Word(rxw3), .o_RX_count(rxc3), .o_SPI_clk(sclk3), .i_SPI_MISO(mosi3),
        .o_SPI_MOSI(mosi3), .o_SPI_CS_n(cs3));

    spi_master_multi_cs #(.SPI_MODE(1), .CLKS_PER_HALF_BIT(2), .WORD_BITS(12), .MSB_FIRST(0),
        .NUM_CS(2), .MAX_WORDS_PER_CS(2), .CS_LEAD_CLKS(1), .CS_INACTIVE_CLKS(1)) u1 (
        .i_clk(clk), .i_rst_n(rst1), .i_TX_count(cnt_in1), .i_TX_CS_sel(sel_in1),
        .i_TX_Word(word_in1), .i_TX_DV(dv_in1), .o_TX_Ready(ready1), .o_RX_DV(dv1),
        .o_RX_Word(rxw1), .o_RX_count(rxc1), .o_SPI_clk(sclk1), .i_SPI_MISO(miso1),
        .o_SPI_MOSI(mosi1), .o_SPI_CS_n(cs1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboards: {index, word}
    logic [31:0] q0[$], q3[$], q1[$];
    logic [31:0] e0, e3, e1;
    int dv0_n = 0, dv0_cyc = 0, dv3_n = 0, dv1_n = 0;
    int dv3_cyc[8];
    logic [1:0] dv0_cs;
    logic [2:0] dv3_cs;

    always @(negedge clk) begin
        if (dv0) begin
            if (q0.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL rx0_unexpected: got word 0x%0h expected no strobe", rxw0);
            end else begin
                e0 = q0.pop_front();
                chk("rx0_word", 32'(rxw0), {16'h0, e0[15:0]});
                chk("rx0_count", 32'(rxc0), {16'h0, e0[31:16]});
            end
            dv0_cyc = cyc; dv0_cs = cs0; dv0_n++;
        end
    end

    always @(negedge clk) begin
        if (dv3) begin
            if (q3.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL rx3_unexpected: got word 0x%0h expected no strobe", rxw3);
            end else begin
                e3 = q3.pop_front();
                chk("rx3_word", 32'(rxw3), {16'h0, e3[15:0]});
                chk("rx3_count", 32'(rxc3), {16'h0, e3[31:16]});
            end
            if (dv3_n < 8) dv3_cyc[dv3_n] = cyc;
            dv3_cs = cs3; dv3_n++;
        end
    end

    always @(negedge clk) begin
        if (dv1) begin
            if (q1.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL rx1_unexpected: got word 0x%0h expected no strobe", rxw1);
            end else begin
                e1 = q1.pop_front();
                chk("rx1_word", 32'(rxw1), {16'h0, e1[15:0]});
                chk("rx1_count", 32'(rxc1), {16'h0, e1[31:16]});
            end
            dv1_n++;
        end
    end

    // MOSI capture: mode 0 on rising SCLK, mode 1 (LSB first) on falling SCLK
    logic [7:0]  cap0 = '0;
    logic [11:0] cap1 = '0;
    always @(posedge sclk0) cap0 <= {cap0[6:0], mosi0};
    always @(negedge sclk1) cap1 <= {mosi1, cap1[11:1]};

    // Mode-1 slave: presents 0x3A5 LSB first on each rising SCLK edge
    logic [11:0] s1_word = 12'h3A5;
    int s1_idx = 0;
    always @(posedge sclk1) begin
        miso1  <= s1_word[s1_idx[3:0]];
        s1_idx <= s1_idx + 1;
    end

    // CS watch for the 3-word mode-3 burst
    logic burst3_on = 1'b0, burst3_done = 1'b0;
    int cs3_bad = 0;
    always @(negedge clk) begin
        if (burst3_on && !burst3_done) begin
            if (cs3 !== 3'b110) cs3_bad++;
            if (dv3 && rxc3 == 2'd2) burst3_done = 1'b1;
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_dv0();
        int start = dv0_n;
        for (int k = 0; k < 300 && dv0_n == start; k++) @(negedge clk);
        chk("dv0_timeout", 32'(dv0_n != start), 32'd1);
    endtask

    task automatic send0(input logic [7:0] w, input logic [1:0] c, input logic s, output int e);
        for (int k = 0; k < 300 && !ready0; k++) @(negedge clk);
        chk("ready0_timeout", 32'(ready0), 32'd1);
        word_in0 = w; cnt_in0 = c; sel_in0 = s; dv_in0 = 1'b1;
        @(posedge clk); #1;
        e = cyc; dv_in0 = 1'b0;
    endtask

    int e_acc, d_cyc, gap_bad;
    int acc3[3];

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst0_cs", 32'(cs0), 32'h3);
        chk("rst0_sclk", 32'(sclk0), 32'h0);
        chk("rst0_mosi", 32'(mosi0), 32'h0);
        chk("rst0_dv", 32'(dv0), 32'h0);
        chk("rst0_word", 32'(rxw0), 32'h0);
        chk("rst0_count", 32'(rxc0), 32'h0);
        chk("rst3_sclk", 32'(sclk3), 32'h1);
        chk("rst3_cs", 32'(cs3), 32'h7);
        rst0 = 1'b1; rst3 = 1'b1; rst1 = 1'b1;
        @(negedge clk);

        // Mode 0 single word 0xA5 on CS1
        q0.push_back({16'd0, 16'h00A5});
        send0(8'hA5, 2'd1, 1'b1, e_acc);
        @(negedge clk);
        chk("cs0_lead", 32'(cs0), 32'h1);
        wait_dv0();
        chk("dv0_latency", 32'(dv0_cyc), 32'(e_acc + 34));
        chk("mosi0_bits", 32'(cap0), 32'hA5);
        chk("cs0_at_dv", 32'(dv0_cs), 32'h1);
        wait_cyc(dv0_cyc + 1);
        chk("cs0_after", 32'(cs0), 32'h3);
        chk("ready0_inactive", 32'(ready0), 32'h0);
        wait_cyc(dv0_cyc + 2);
        chk("ready0_idle", 32'(ready0), 32'h1);

        // Count 2 with a 50-cycle stall before the second word
        q0.push_back({16'd0, 16'h0011});
        send0(8'h11, 2'd2, 1'b0, e_acc);
        wait_dv0();
        gap_bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cs0 !== 2'b10 || sclk0 !== 1'b0) gap_bad++;
        end
        chk("gap_cs_sclk", 32'(gap_bad), 32'h0);
        chk("ready0_gap", 32'(ready0), 32'h1);
        q0.push_back({16'd1, 16'h0022});
        send0(8'h22, 2'd3, 1'b1, e_acc);
        wait_dv0();
        chk("dv0_latency_next", 32'(dv0_cyc), 32'(e_acc + 33));
        wait_cyc(dv0_cyc + 1);
        chk("cs0_after_gap", 32'(cs0), 32'h3);

        // Reset in the middle of a word
        send0(8'h77, 2'd1, 1'b1, e_acc);
        repeat (15) @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
        chk("mrst_cs", 32'(cs0), 32'h3);
        chk("mrst_sclk", 32'(sclk0), 32'h0);
        chk("mrst_mosi", 32'(mosi0), 32'h0);
        chk("mrst_dv", 32'(dv0), 32'h0);
        chk("mrst_word", 32'(rxw0), 32'h0);
        chk("mrst_count", 32'(rxc0), 32'h0);
        rst0 = 1'b1;
        repeat (40) @(negedge clk);
        q0.push_back({16'd0, 16'h003C});
        send0(8'h3C, 2'd1, 1'b0, e_acc);
        wait_dv0();
        chk("dv0_latency_rst", 32'(dv0_cyc), 32'(e_acc + 34));

        // Mode 3, three words with DV held
        cnt_in3 = 2'd3; sel_in3 = 2'd0; dv_in3 = 1'b1;
        for (int w = 0; w < 3; w++) begin
            word_in3 = 8'(w + 1);
            q3.push_back({16'(w), 16'(w + 1)});
            for (int k = 0; k < 300 && !ready3; k++) @(negedge clk);
            chk("ready3_timeout", 32'(ready3), 32'd1);
            @(posedge clk); #1;
            acc3[w] = cyc;
            burst3_on = 1'b1;
        end
        dv_in3 = 1'b0;
        for (int k = 0; k < 300 && dv3_n < 3; k++) @(negedge clk);
        chk("dv3_timeout", 32'(dv3_n >= 3), 32'd1);
        chk("acc3_gap1", 32'(acc3[1] - acc3[0]), 32'd35);
        chk("acc3_gap2", 32'(acc3[2] - acc3[1]), 32'd34);
        chk("dv3_gap1", 32'(dv3_cyc[1] - dv3_cyc[0]), 32'd34);
        chk("dv3_gap2", 32'(dv3_cyc[2] - dv3_cyc[1]), 32'd34);
        chk("cs3_low_burst", 32'(cs3_bad), 32'd0);
        d_cyc = dv3_cyc[2];
        wait_cyc(d_cyc + 1);
        chk("cs3_after", 32'(cs3), 32'h7);
        chk("ready3_d1", 32'(ready3), 32'h0);
        wait_cyc(d_cyc + 2);
        chk("ready3_d2", 32'(ready3), 32'h0);
        wait_cyc(d_cyc + 3);
        chk("ready3_d3", 32'(ready3), 32'h1);

        // Count 0 with out-of-range select
        q3.push_back({16'd0, 16'h0096});
        word_in3 = 8'h96; cnt_in3 = 2'd0; sel_in3 = 2'd3; dv_in3 = 1'b1;
        @(posedge clk); #1;
        e_acc = cyc; dv_in3 = 1'b0;
        @(negedge clk);
        chk("cs3_none", 32'(cs3), 32'h7);
        for (int k = 0; k < 300 && dv3_n < 4; k++) @(negedge clk);
        chk("dv3_single", 32'(dv3_cyc[3]), 32'(e_acc + 34));
        chk("cs3_none_dv", 32'(dv3_cs), 32'h7);
        wait_cyc(dv3_cyc[3] + 3);
        chk("ready3_single", 32'(ready3), 32'h1);

        // Mode 1, W=12, LSB first
        q1.push_back({16'd0, 16'h03A5});
        for (int k = 0; k < 300 && !ready1; k++) @(negedge clk);
        word_in1 = 12'h5C3; cnt_in1 = 2'd1; sel_in1 = 1'b0; dv_in1 = 1'b1;
        @(posedge clk); #1;
        dv_in1 = 1'b0;
        @(negedge clk);
        chk("cs1_lead", 32'(cs1), 32'h2);
        for (int k = 0; k < 300 && dv1_n < 1; k++) @(negedge clk);
        chk("dv1_timeout", 32'(dv1_n), 32'd1);
        chk("mosi1_bits", 32'(cap1), 32'h5C3);

        repeat (5) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q3_drained", 32'(q3.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
